// File: rtl/twiddle_mul_64.sv
// Complex sample x twiddle multiplier with a registered twiddle ROM address generator.
// Optional macro TW_MUL_SAT_EN: saturate out-of-range results instead of wrapping.
module twiddle_mul_64 #(
  parameter  int DATA_W    = 13,
  parameter  int TW_W      = 9,
  parameter  int FRAME_LEN = 64,
  localparam int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic        [ADDR_W-1:0] tw_addr,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  output logic                     out_valid,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     ovf
);

  localparam int PW = DATA_W + TW_W;   // product width
  localparam int SW = PW + 1;          // sum width
  localparam int SH = TW_W - 2;        // Q-format shift
  localparam int RW = SW - SH;         // rounded width
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic signed [SW-1:0] RND = {{(SW-1){1'b0}}, 1'b1} << (TW_W - 3);

  logic        [ADDR_W-1:0] r_idx;
  logic                     r_s1_valid, r_s1_sof, r_s1_eof;
  logic signed [DATA_W-1:0] r_s1_re, r_s1_im;
  logic                     r_s2_valid, r_s2_sof, r_s2_eof;
  logic signed [PW-1:0]     r_p_rr, r_p_ii, r_p_ri, r_p_ir;

  logic signed [PW-1:0]     w_s1_re_x, w_s1_im_x, w_tw_re_x, w_tw_im_x;
  logic signed [SW-1:0]     w_re_rnd, w_im_rnd;
  logic signed [RW-1:0]     w_re_r, w_im_r;
  logic                     w_re_ovf, w_im_ovf;
  logic signed [DATA_W-1:0] w_re_out, w_im_out;
  logic                     w_unused;

  // A start-of-frame sample always takes address 0, restarting the frame mid-way if needed.
  assign tw_addr = (in_valid && in_sof) ? '0 : r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      r_s2_valid <= r_s1_valid;
      if (in_valid)
        r_idx <= (tw_addr == ADDR_LAST) ? '0 : tw_addr + ADDR_W'(1);
    end
  end

  assign w_s1_re_x = PW'(r_s1_re);
  assign w_s1_im_x = PW'(r_s1_im);
  assign w_tw_re_x = PW'(tw_re);
  assign w_tw_im_x = PW'(tw_im);

  // Stage 1 lines data up with the registered ROM output; stage 2 holds the products.
  always_ff @(posedge clk) begin
    r_s1_re  <= in_re;
    r_s1_im  <= in_im;
    r_s1_sof <= (tw_addr == '0);
    r_s1_eof <= (tw_addr == ADDR_LAST);
    r_s2_sof <= r_s1_sof;
    r_s2_eof <= r_s1_eof;
    r_p_rr   <= w_s1_re_x * w_tw_re_x;
    r_p_ii   <= w_s1_im_x * w_tw_im_x;
    r_p_ri   <= w_s1_re_x * w_tw_im_x;
    r_p_ir   <= w_s1_im_x * w_tw_re_x;
  end

  assign w_re_rnd = SW'(r_p_rr) - SW'(r_p_ii) + RND;
  assign w_im_rnd = SW'(r_p_ri) + SW'(r_p_ir) + RND;
  // Taking the upper slice is the arithmetic right shift by SH.
  assign w_re_r   = w_re_rnd[SW-1:SH];
  assign w_im_r   = w_im_rnd[SW-1:SH];
  assign w_unused = ^{w_re_rnd[SH-1:0], w_im_rnd[SH-1:0]};

  always_comb begin
    w_re_ovf = !((&w_re_r[RW-1:DATA_W-1]) || !(|w_re_r[RW-1:DATA_W-1]));
    w_im_ovf = !((&w_im_r[RW-1:DATA_W-1]) || !(|w_im_r[RW-1:DATA_W-1]));
    w_re_out = w_re_r[DATA_W-1:0];
    w_im_out = w_im_r[DATA_W-1:0];
`ifdef TW_MUL_SAT_EN
    if (w_re_ovf)
      w_re_out = w_re_r[RW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    if (w_im_ovf)
      w_im_out = w_im_r[RW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= r_s2_valid;
      out_sof   <= r_s2_valid & r_s2_sof;
      out_eof   <= r_s2_valid & r_s2_eof;
      if (r_s2_valid) begin
        out_re <= w_re_out;
        out_im <= w_im_out;
        if (w_re_ovf || w_im_ovf)
          ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_mul_64.sv
// Scoreboard bench for twiddle_mul_64 with a registered twiddle ROM model.
module tb_twiddle_mul_64;

  localparam int DW = 13;
  localparam int TW = 9;
  localparam int FL = 64;
  localparam int AW = 6;
  localparam longint LIM = longint'(1) << (DW - 1);

  logic                 clk = 1'b0;
  logic                 rst, in_valid, in_sof;
  logic signed [DW-1:0] in_re, in_im;
  logic        [AW-1:0] tw_addr;
  logic signed [TW-1:0] tw_re, tw_im;
  logic                 out_valid, out_sof, out_eof, ovf;
  logic signed [DW-1:0] out_re, out_im;

  twiddle_mul_64 #(.DATA_W(DW), .TW_W(TW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_re(out_re), .out_im(out_im), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int rom_re[FL];
  int rom_im[FL];
  always @(posedge clk) begin
    tw_re <= TW'(rom_re[tw_addr]);
    tw_im <= TW'(rom_im[tw_addr]);
  end

  typedef struct {
    int re; int im; bit sof; bit eof; bit ov; int stamp;
  } exp_t;
  exp_t q[$];

  int  n_checks = 0, n_pass = 0;
  int  cyc = 0;
  bit  prev_rst = 1'b0;
  int  m_idx = 0;
  int  last_re = 0, last_im = 0;
  bit  exp_ovf = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int reduce(input longint r);
`ifdef TW_MUL_SAT_EN
    if (r > LIM - 1) return int'(LIM - 1);
    if (r < -LIM) return int'(-LIM);
    return int'(r);
`else
    longint w;
    w = r & (2 * LIM - 1);
    if (w >= LIM) w -= 2 * LIM;
    return int'(w);
`endif
  endfunction

  task automatic model(input int a, input int b, input int c, input int d,
                       output int ore, output int oim, output bit ov);
    longint xr, xi, rr, ri;
    xr = longint'(a) * c - longint'(b) * d;
    xi = longint'(a) * d + longint'(b) * c;
    rr = (xr + (longint'(1) << (TW - 3))) >>> (TW - 2);
    ri = (xi + (longint'(1) << (TW - 3))) >>> (TW - 2);
    ov = (rr > LIM - 1) || (rr < -LIM) || (ri > LIM - 1) || (ri < -LIM);
    ore = reduce(rr);
    oim = reduce(ri);
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_rst <= rst;
  end

  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (prev_rst) begin
        q.delete();
        last_re = 0; last_im = 0; exp_ovf = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
      end else if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("latency", cyc - e.stamp, 3);
          check("out_re", out_re, e.re);
          check("out_im", out_im, e.im);
          check("out_sof", out_sof, e.sof);
          check("out_eof", out_eof, e.eof);
          if (e.ov) exp_ovf = 1'b1;
          check("ovf", ovf, exp_ovf);
          last_re = e.re; last_im = e.im;
        end
      end else begin
        if (q.size() != 0 && cyc - q[0].stamp >= 3) begin
          check("missing_out_valid", 0, 1);
          void'(q.pop_front());
        end
        check("hold_re", out_re, last_re);
        check("hold_im", out_im, last_im);
      end
    end
  end

  task automatic drive(input bit v, input bit sof, input int re, input int im,
                       input bit fix = 1'b0, input int fre = 0, input int fim = 0);
    exp_t e;
    int   a;
    @(posedge clk);
    #1;
    in_valid = v; in_sof = sof; in_re = DW'(re); in_im = DW'(im);
    #1;
    if (v) begin
      a = sof ? 0 : m_idx;
      check("tw_addr", tw_addr, a);
      model(re, im, rom_re[a], rom_im[a], e.re, e.im, e.ov);
      if (fix) begin e.re = fre; e.im = fim; end
      e.sof = (a == 0);
      e.eof = (a == FL - 1);
      e.stamp = cyc;
      q.push_back(e);
      m_idx = (a == FL - 1) ? 0 : a + 1;
    end else begin
      check("idx_hold", tw_addr, m_idx);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
  endtask

  function automatic int rnd_data();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  task automatic send_rand(input bit sof);
    drive(1'b1, sof, rnd_data(), rnd_data());
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_idx = 0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_im = '0;
    for (int i = 0; i < FL; i++) begin
      rom_re[i] = int'($urandom_range(0, 256)) - 128;
      rom_im[i] = int'($urandom_range(0, 256)) - 128;
    end
    rom_re[0]  = 128; rom_im[0]  = 0;
    rom_re[10] = 91;  rom_im[10] = -91;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_idx = 0;
    #1;
    check("tw_addr_after_rst", tw_addr, 0);

    // unity twiddle at address 0
    drive(1'b1, 1'b1, 100, 0, 1'b1, 100, 0);
    idle(4);

    // 45-degree twiddle at address 10
    send_rand(1'b1);
    for (int i = 1; i < 10; i++) send_rand(1'b0);
    drive(1'b1, 1'b0, 128, 0, 1'b1, 91, -91);
    idle(4);

    // out-of-range result at address 10
    send_rand(1'b1);
    for (int i = 1; i < 10; i++) send_rand(1'b0);
`ifdef TW_MUL_SAT_EN
    drive(1'b1, 1'b0, -4096, -4096, 1'b1, -4096, 0);
`else
    drive(1'b1, 1'b0, -4096, -4096, 1'b1, 2368, 0);
`endif
    idle(4);
    check("ovf_sticky", ovf, 1);

    // full frame back-to-back, then wrap into the next frame
    send_rand(1'b1);
    for (int i = 1; i < FL + 5; i++) send_rand(1'b0);
    idle(4);

    // mid-frame restart, then gapped input
    send_rand(1'b1);
    for (int i = 1; i < 20; i++) send_rand(1'b0);
    send_rand(1'b1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) send_rand(1'b0);
      else idle(1);
    end
    idle(4);

    // reset with samples in flight
    send_rand(1'b1);
    send_rand(1'b0);
    send_rand(1'b0);
    pulse_rst();
    send_rand(1'b0);
    send_rand(1'b0);
    send_rand(1'b0);
    idle(6);

    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/twiddle_mul_64.md
TWIDDLE_MUL_64 -- requirements
Module: twiddle_mul_64

Interface
REQ-001 The block SHALL have parameter DATA_W, default 13, giving the signed input/output sample width.
REQ-002 The block SHALL have parameter TW_W, default 9, giving the signed twiddle width in Q(TW_W-2) format (128 = 1.0).
REQ-003 The block SHALL have parameter FRAME_LEN, default 64, giving the twiddle table depth and frame length; ADDR_W = clog2(FRAME_LEN).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: input sample valid.
REQ-007 The block SHALL have port in_sof, input, 1 bit: start of frame; sampled only when in_valid=1.
REQ-008 The block SHALL have ports in_re and in_im, input, DATA_W bits each, signed: input sample.
REQ-009 The block SHALL have port tw_addr, output, ADDR_W bits: address to the twiddle ROM.
REQ-010 The block SHALL have ports tw_re and tw_im, input, TW_W bits each, signed: twiddle from the ROM, valid one cycle after tw_addr (registered ROM).
REQ-011 The block SHALL have ports out_valid, out_sof and out_eof, output, 1 bit each: output valid, first-of-frame and last-of-frame flags.
REQ-012 The block SHALL have ports out_re and out_im, output, DATA_W bits each, signed: product sample.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky overflow flag.

Function
REQ-014 The block SHALL hold a sample index idx (ADDR_W bits); tw_addr SHALL be combinational: 0 when in_valid & in_sof, else idx.
REQ-015 Each accepted sample (in_valid=1) SHALL advance idx to tw_addr+1, wrapping from FRAME_LEN-1 to 0; idx SHALL hold when in_valid=0.
REQ-016 An in_sof arriving mid-frame SHALL restart the frame: that sample uses address 0, with no error indication.
REQ-017 Pipeline stage 1 SHALL register the input data, valid and flags so they align with the ROM twiddle output.
REQ-018 Stage 2 SHALL register the four full-precision products in_re*tw_re, in_im*tw_im, in_re*tw_im and in_im*tw_re, each DATA_W+TW_W bits.
REQ-019 Stage 3 SHALL compute re = in_re*tw_re - in_im*tw_im and im = in_re*tw_im + in_im*tw_re at DATA_W+TW_W+1 bits, then round as (x + 2^(TW_W-3)) >>> (TW_W-2) using arithmetic shift, then apply the width reduction of REQ-028/029, then register the result.
REQ-020 Latency SHALL be exactly 3 cycles from an accepted in_valid to the matching out_valid; the block SHALL sustain one sample per cycle with no backpressure.
REQ-021 out_sof SHALL accompany the sample taken at address 0, and out_eof the sample taken at address FRAME_LEN-1.
REQ-022 ovf SHALL set on any output sample whose re or im rounded result lies outside the DATA_W signed range, and SHALL stay set until rst.
REQ-023 While out_valid=0, out_re and out_im SHALL hold their last values.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL clear idx, all pipeline valid bits, out_valid, out_sof, out_eof, ovf, out_re and out_im to 0.
REQ-025 A reset asserted mid-frame SHALL discard all in-flight samples, with out_valid=0 from the cycle after the reset edge.
REQ-026 The first accepted sample after reset SHALL use address 0, regardless of in_sof.
REQ-027 Data registers other than the output registers need no reset.

Configuration
REQ-028 With macro TW_MUL_SAT_EN defined, out-of-range results SHALL saturate to -2^(DATA_W-1) or 2^(DATA_W-1)-1.
REQ-029 Without TW_MUL_SAT_EN, results SHALL be truncated to the low DATA_W bits (two's-complement wrap), and ovf SHALL still report the overflow.

Verification
REQ-030 The bench SHALL apply in_sof with input (100,0) at address 0, tw=(128,0), and check out=(100,0) with out_sof=1 exactly 3 cycles later.
REQ-031 The bench SHALL apply in_sof plus 10 samples, then input (128,0) at address 10 with tw=(91,-91), and check out=(91,-91).
REQ-032 The bench SHALL apply input (-4096,-4096) at address 10 with tw=(91,-91) and check: with the macro, out=(-4096,0) and ovf=1; without it, out=(2368,0) and ovf=1.
REQ-033 The bench SHALL apply 64 back-to-back samples, then more, and check out_eof on the 64th sample and tw_addr=0 on the 65th.
REQ-034 The bench SHALL apply in_sof at idx=20, and separately in_valid gaps, and check that tw_addr=0 for the in_sof sample, idx holds during gaps, and latency stays 3.
REQ-035 The bench SHALL assert rst for one cycle with 3 samples in flight and check out_valid=0 next cycle, ovf=0, and that the next sample uses tw_addr=0.
